// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates conditional branches and jumps, flags
// mispredictions, issues BTB updates and keeps saturating resolution statistics.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [2:0]       in_br_type,
   input  logic [1:0]       in_j_type,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_taken,
   output logic             out_miss,
   output logic             out_is_jump,
   output logic [XLEN-1:0]  out_next_pc,
   output logic [XLEN-1:0]  out_link,
   output logic             btb_upd_valid,
   output logic [XLEN-1:0]  btb_upd_pc,
   output logic [XLEN-1:0]  btb_upd_target,
   output logic             btb_upd_taken,
   input  logic             stat_clear,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_misses
);
   localparam logic [XLEN-1:0]  PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0]  JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   logic             out_valid_q, btb_valid_q, counted_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_taken_q, out_miss_q, out_is_jump_q, btb_taken_q;
   logic [XLEN-1:0]  out_next_pc_q, out_link_q, btb_pc_q, btb_target_q;
   logic [CNT_W-1:0] stat_br_q, stat_ms_q;

   logic             accept_s, handshake_s, cond_taken_s;
   logic             out_taken_d, out_miss_d, out_is_jump_d;
   logic [XLEN-1:0]  seq_pc_s, br_target_s, jalr_sum_s, target_s;
   logic [XLEN-1:0]  out_next_pc_d, out_link_d;

   assign in_ready    = !out_valid_q || out_ready;
   assign accept_s    = in_valid && in_ready && !flush;
   assign handshake_s = out_valid_q && out_ready && !flush && counted_q;
   assign seq_pc_s    = in_pc + PC_STEP;
   assign br_target_s = in_pc + in_imm;
   assign jalr_sum_s  = in_rs1 + in_imm;

   // Conditional branch direction from funct3
   always_comb begin
      cond_taken_s = 1'b0;
      case (in_br_type)
         3'd0:    cond_taken_s = (in_rs1 == in_rs2);
         3'd1:    cond_taken_s = (in_rs1 != in_rs2);
         3'd4:    cond_taken_s = ($signed(in_rs1) <  $signed(in_rs2));
         3'd5:    cond_taken_s = ($signed(in_rs1) >= $signed(in_rs2));
         3'd6:    cond_taken_s = (in_rs1 <  in_rs2);
         3'd7:    cond_taken_s = (in_rs1 >= in_rs2);
         default: cond_taken_s = 1'b0;
      endcase
   end

   // Resolved direction, target, next PC, link and mispredict for the incoming op
   always_comb begin
      out_taken_d   = 1'b0;
      out_is_jump_d = 1'b0;
      target_s      = br_target_s;
      case (in_j_type)
         2'd0: out_taken_d = cond_taken_s;
         2'd1: begin
            out_taken_d   = 1'b1;
            out_is_jump_d = 1'b1;
         end
         2'd2: begin
            out_taken_d   = 1'b1;
            out_is_jump_d = 1'b1;
            target_s      = jalr_sum_s & JALR_MASK;
         end
         default: out_taken_d = 1'b0;
      endcase
      if (out_taken_d) out_next_pc_d = target_s;
      else             out_next_pc_d = seq_pc_s;
      if (out_is_jump_d) out_link_d = seq_pc_s;
      else               out_link_d = XLEN_ZERO;
      out_miss_d = (out_taken_d != in_pred_taken) ||
                   (out_taken_d && (in_pred_target != target_s));
   end

   // Result and BTB-update registers; BTB pulse lasts one cycle regardless of stalls
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_valid_q   <= 1'b0;
         btb_valid_q   <= 1'b0;
         counted_q     <= 1'b0;
         out_tag_q     <= {TAG_W{1'b0}};
         out_taken_q   <= 1'b0;
         out_miss_q    <= 1'b0;
         out_is_jump_q <= 1'b0;
         out_next_pc_q <= XLEN_ZERO;
         out_link_q    <= XLEN_ZERO;
         btb_pc_q      <= XLEN_ZERO;
         btb_target_q  <= XLEN_ZERO;
         btb_taken_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         btb_valid_q <= 1'b0;
      end else begin
         btb_valid_q <= accept_s && (in_j_type == 2'd0);
         if (accept_s) begin
            out_valid_q   <= 1'b1;
            counted_q     <= (in_j_type != 2'd3);
            out_tag_q     <= in_tag;
            out_taken_q   <= out_taken_d;
            out_miss_q    <= out_miss_d;
            out_is_jump_q <= out_is_jump_d;
            out_next_pc_q <= out_next_pc_d;
            out_link_q    <= out_link_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept_s && (in_j_type == 2'd0)) begin
            btb_pc_q     <= in_pc;
            btb_target_q <= br_target_s;
            btb_taken_q  <= out_taken_d;
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_br_q <= CNT_ZERO;
         stat_ms_q <= CNT_ZERO;
      end else if (stat_clear) begin
         stat_br_q <= CNT_ZERO;
         stat_ms_q <= CNT_ZERO;
      end else begin
         if (handshake_s && (stat_br_q != CNT_MAX)) stat_br_q <= stat_br_q + CNT_ONE;
         if (handshake_s && out_miss_q && (stat_ms_q != CNT_MAX)) stat_ms_q <= stat_ms_q + CNT_ONE;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_tag        = out_tag_q;
   assign out_taken      = out_taken_q;
   assign out_miss       = out_miss_q;
   assign out_is_jump    = out_is_jump_q;
   assign out_next_pc    = out_next_pc_q;
   assign out_link       = out_link_q;
   assign btb_upd_valid  = btb_valid_q;
   assign btb_upd_pc     = btb_pc_q;
   assign btb_upd_target = btb_target_q;
   assign btb_upd_taken  = btb_taken_q;
   assign stat_branches  = stat_br_q;
   assign stat_misses    = stat_ms_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_branch_resolve_unit;
   logic        CLK = 1'b0, nRST = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
   logic [3:0]  in_tag = 4'd0;
   logic [31:0] in_pc = 32'd0, in_rs1 = 32'd0, in_rs2 = 32'd0, in_imm = 32'd0;
   logic [2:0]  in_br_type = 3'd0;
   logic [1:0]  in_j_type = 2'd0;
   logic        in_pred_taken = 1'b0;
   logic [31:0] in_pred_target = 32'd0;
   logic        out_valid, out_ready = 1'b1;
   logic [3:0]  out_tag;
   logic        out_taken, out_miss, out_is_jump;
   logic [31:0] out_next_pc, out_link;
   logic        btb_upd_valid, btb_upd_taken;
   logic [31:0] btb_upd_pc, btb_upd_target;
   logic        stat_clear = 1'b0;
   logic [1:0]  stat_branches, stat_misses;

   int total = 0;
   int bad = 0;

   branch_resolve_unit #(.XLEN(32), .TAG_W(4), .CNT_W(2)) dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_br_type(in_br_type), .in_j_type(in_j_type),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_taken(out_taken), .out_miss(out_miss), .out_is_jump(out_is_jump),
      .out_next_pc(out_next_pc), .out_link(out_link),
      .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
      .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
      .stat_clear(stat_clear), .stat_branches(stat_branches), .stat_misses(stat_misses)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        taken;
      logic        miss;
      logic        is_jump;
      logic [31:0] next_pc;
      logic [31:0] link;
      logic [31:0] target;
   } res_t;

   // Architectural meaning of one branch/jump instruction
   function automatic res_t model_calc(input logic [2:0] bt, input logic [1:0] jt,
                                       input logic [31:0] pc, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm,
                                       input logic pt, input logic [31:0] ptg);
      res_t r;
      r = '0;
      r.target = (jt == 2'd2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      if (jt == 2'd1 || jt == 2'd2) r.taken = 1'b1;
      else if (jt == 2'd0) begin
         case (bt)
            3'd0: r.taken = (rs1 == rs2);
            3'd1: r.taken = (rs1 != rs2);
            3'd4: r.taken = (int'(rs1) <  int'(rs2));
            3'd5: r.taken = (int'(rs1) >= int'(rs2));
            3'd6: r.taken = (rs1 <  rs2);
            3'd7: r.taken = (rs1 >= rs2);
            default: r.taken = 1'b0;
         endcase
      end
      r.is_jump = (jt == 2'd1 || jt == 2'd2);
      r.link    = r.is_jump ? pc + 32'd4 : 32'd0;
      r.next_pc = r.taken ? r.target : pc + 32'd4;
      r.miss    = (r.taken != pt) || (r.taken && ptg != r.target);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state
   res_t        m_res = '0;
   logic        m_valid = 1'b0, m_counted = 1'b0, m_btb = 1'b0, m_btb_tk = 1'b0;
   logic [31:0] m_btb_pc = 32'd0, m_btb_tgt = 32'd0;
   logic [3:0]  m_tag = 4'd0;
   int          m_br = 0, m_ms = 0;
   res_t        m_calc;
   logic        m_acc, m_hs;

   assign m_calc = model_calc(in_br_type, in_j_type, in_pc, in_rs1, in_rs2, in_imm,
                              in_pred_taken, in_pred_target);
   assign m_acc  = in_valid && (!m_valid || out_ready) && !flush;
   assign m_hs   = m_valid && out_ready && !flush && m_counted;

   // Model update on each edge
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_valid <= 1'b0; m_btb <= 1'b0; m_counted <= 1'b0; m_res <= '0; m_tag <= 4'd0;
         m_btb_pc <= 32'd0; m_btb_tgt <= 32'd0; m_btb_tk <= 1'b0; m_br <= 0; m_ms <= 0;
      end else begin
         if (stat_clear) begin
            m_br <= 0;
            m_ms <= 0;
         end else begin
            if (m_hs) m_br <= (m_br < 3) ? m_br + 1 : 3;
            if (m_hs && m_res.miss) m_ms <= (m_ms < 3) ? m_ms + 1 : 3;
         end
         if (flush) begin
            m_valid <= 1'b0;
            m_btb   <= 1'b0;
         end else begin
            m_btb <= m_acc && (in_j_type == 2'd0);
            if (m_acc) begin
               m_valid <= 1'b1; m_res <= m_calc; m_tag <= in_tag;
               m_counted <= (in_j_type != 2'd3);
            end else if (out_ready) m_valid <= 1'b0;
            if (m_acc && in_j_type == 2'd0) begin
               m_btb_pc <= in_pc; m_btb_tgt <= in_pc + in_imm; m_btb_tk <= m_calc.taken;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      chk("m_in_ready", in_ready, !m_valid || out_ready);
      chk("m_out_valid", out_valid, m_valid);
      chk("m_btb_valid", btb_upd_valid, m_btb);
      chk("m_stat_br", stat_branches, m_br);
      chk("m_stat_ms", stat_misses, m_ms);
      if (m_valid) begin
         chk("m_tag", out_tag, m_tag);
         chk("m_taken", out_taken, m_res.taken);
         chk("m_miss", out_miss, m_res.miss);
         chk("m_is_jump", out_is_jump, m_res.is_jump);
         chk("m_next_pc", out_next_pc, m_res.next_pc);
         chk("m_link", out_link, m_res.link);
      end
      if (m_btb) begin
         chk("m_btb_pc", btb_upd_pc, m_btb_pc);
         chk("m_btb_tgt", btb_upd_target, m_btb_tgt);
         chk("m_btb_tk", btb_upd_taken, m_btb_tk);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [2:0] bt, input logic [1:0] jt, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
      in_valid = 1'b1; in_br_type = bt; in_j_type = jt; in_pc = pc;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_taken = pt; in_pred_target = ptg;
      in_tag = in_tag + 4'd1;
   endtask

   task automatic clear_stats();
      in_valid = 1'b0; stat_clear = 1'b1;
      step();
      stat_clear = 1'b0;
   endtask

   typedef struct packed {
      logic [2:0]  bt;
      logic [1:0]  jt;
      logic [31:0] pc, rs1, rs2, imm;
      logic        pt;
      logic [31:0] ptg;
   } vec_t;
   vec_t vecs [8];

   initial begin
      vecs[0] = {3'd5, 2'd0, 32'h1000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0020, 1'b0, 32'h0};
      vecs[1] = {3'd7, 2'd0, 32'h1100, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFF0, 1'b1, 32'h10F0};
      vecs[2] = {3'd1, 2'd0, 32'h1200, 32'h0000_0007, 32'h0000_0007, 32'h0000_0100, 1'b1, 32'h1300};
      vecs[3] = {3'd2, 2'd0, 32'h1300, 32'h0000_0001, 32'h0000_0002, 32'h0000_0008, 1'b0, 32'h0};
      vecs[4] = {3'd0, 2'd1, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0000_0020, 1'b1, 32'h0000_0010};
      vecs[5] = {3'd0, 2'd2, 32'h1500, 32'h0000_2003, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_2000};
      vecs[6] = {3'd0, 2'd3, 32'h1600, 32'h0, 32'h0, 32'h0000_0040, 1'b1, 32'h1640};
      vecs[7] = {3'd3, 2'd0, 32'h1700, 32'h5, 32'h9, 32'h0000_0010, 1'b1, 32'h1710};

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_btb_valid", btb_upd_valid, 1'b0);
      chk("rst_next_pc", out_next_pc, 32'h0);
      chk("rst_btb_pc", btb_upd_pc, 32'h0);
      chk("rst_stats", {stat_branches, stat_misses}, 4'h0);
      nRST = 1'b1;
      step();

      // BEQ taken, predicted not-taken
      drive(3'd0, 2'd0, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      chk("beq_valid", out_valid, 1'b1);
      chk("beq_taken", out_taken, 1'b1);
      chk("beq_miss", out_miss, 1'b1);
      chk("beq_next_pc", out_next_pc, 32'h140);
      chk("beq_btb", btb_upd_valid, 1'b1);
      chk("beq_btb_tgt", btb_upd_target, 32'h140);
      step();
      chk("beq_btb_off", btb_upd_valid, 1'b0);
      chk("beq_drained", out_valid, 1'b0);
      chk("beq_stats", {stat_branches, stat_misses}, {2'd1, 2'd1});

      // JALR correctly predicted
      drive(3'd0, 2'd2, 32'h200, 32'h1001, 32'h0, 32'h2, 1'b1, 32'h1002);
      step();
      chk("jalr_next_pc", out_next_pc, 32'h1002);
      chk("jalr_link", out_link, 32'h204);
      chk("jalr_miss", out_miss, 1'b0);
      chk("jalr_btb", btb_upd_valid, 1'b0);

      // Signed vs unsigned less-than on the same operands, then reserved j_type
      drive(3'd4, 2'd0, 32'h240, 32'hFFFF_FFFF, 32'h1, 32'h8, 1'b0, 32'h0);
      step();
      chk("blt_taken", out_taken, 1'b1);
      drive(3'd6, 2'd0, 32'h240, 32'hFFFF_FFFF, 32'h1, 32'h8, 1'b0, 32'h0);
      step();
      chk("bltu_taken", out_taken, 1'b0);
      drive(3'd0, 2'd3, 32'h600, 32'h3, 32'h3, 32'h40, 1'b1, 32'h640);
      step();
      chk("rsv_next_pc", out_next_pc, 32'h604);
      chk("rsv_link_jump", {out_link, out_is_jump, out_taken}, 34'h0);
      chk("rsv_btb", btb_upd_valid, 1'b0);
      clear_stats();

      // Stall for three cycles with a second op waiting
      out_ready = 1'b0;
      drive(3'd1, 2'd0, 32'h300, 32'h1, 32'h2, 32'h10, 1'b1, 32'h310);
      step();
      chk("stall_btb_first", btb_upd_valid, 1'b1);
      drive(3'd0, 2'd0, 32'h400, 32'h1, 32'h2, 32'h10, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_hold_pc", out_next_pc, 32'h310);
         chk("stall_btb_once", btb_upd_valid, 1'b0);
      end
      chk("stall_no_count", stat_branches, 2'd0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("stall_count", stat_branches, 2'd1);
      chk("stall_next_op", out_next_pc, 32'h404);
      step();
      clear_stats();

      // Flush with a result pending and a new op offered
      drive(3'd0, 2'd1, 32'h500, 32'h0, 32'h0, 32'h20, 1'b1, 32'h520);
      step();
      chk("fl_pre_valid", out_valid, 1'b1);
      drive(3'd0, 2'd0, 32'h540, 32'h9, 32'h9, 32'h8, 1'b0, 32'h0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_stats", stat_branches, 2'd0);
      step();
      chk("fl_btb", btb_upd_valid, 1'b0);
      chk("fl_valid2", out_valid, 1'b0);

      // Saturation with a 2-bit counter, then clear beside a handshake
      clear_stats();
      for (int i = 0; i < 5; i++) begin
         drive(3'd0, 2'd0, 32'h700 + 32'(i * 4), 32'h4, 32'h4, 32'h80, 1'b0, 32'h0);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("sat_misses", stat_misses, 2'd3);
      chk("sat_branches", stat_branches, 2'd3);
      drive(3'd0, 2'd0, 32'h800, 32'h4, 32'h4, 32'h80, 1'b0, 32'h0);
      step();
      in_valid = 1'b0; stat_clear = 1'b1;
      step();
      stat_clear = 1'b0;
      chk("clr_over_hs", {stat_branches, stat_misses}, 4'h0);

      // Table-driven traffic with random handshake pressure
      for (int i = 0; i < 80; i++) begin
         vec_t v;
         v = vecs[$urandom_range(0, 7)];
         drive(v.bt, v.jt, v.pc, v.rs1, v.rs2, v.imm, v.pt, v.ptg);
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         stat_clear = ($urandom_range(0, 19) == 0);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; stat_clear = 1'b0;

      // Reset while a result is stalled
      out_ready = 1'b0;
      drive(3'd0, 2'd0, 32'h900, 32'h1, 32'h1, 32'h4, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      step();
      #2 nRST = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_data", {out_next_pc, btb_upd_target}, 64'h0);
      @(posedge CLK);
      #1 nRST = 1'b1; out_ready = 1'b1;
      step();
      step();
      chk("post_rst_quiet", {out_valid, btb_upd_valid, stat_branches, stat_misses}, 6'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
